// File: rtl/tetris_pkg.sv
// Shared playfield definitions: board geometry, RAM address width and cell type codes.
// Used by the cell writer, the scan-side fetch and the type->RGB colour lookup.
// Pure declarations; no logic, no latency, no flow control.
package tetris_pkg;

  // Cell type field width and board geometry in cells
  localparam int CELL_W     = 3;
  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;

  // Board RAM address width; BOARD_COLS*BOARD_ROWS-1 = 199 fits in 8 bits
  localparam int ADDR_W = 8;

  // Cell type codes as stored in the board RAM
  localparam logic [CELL_W-1:0] T_NONE   = 3'b000;
  localparam logic [CELL_W-1:0] T_CYAN   = 3'b001;
  localparam logic [CELL_W-1:0] T_BLUE   = 3'b010;
  localparam logic [CELL_W-1:0] T_YELLOW = 3'b011;
  localparam logic [CELL_W-1:0] T_GREEN  = 3'b100;
  localparam logic [CELL_W-1:0] T_PURPLE = 3'b101;
  localparam logic [CELL_W-1:0] T_RED    = 3'b110;
  localparam logic [CELL_W-1:0] T_ORANGE = 3'b111;

endpackage

// File: rtl/cell_axis_counter.sv
// Cell index / sub-cell pixel counter for one beam axis, with an optional running base (index*BASE_STEP).
// Zero latency: outputs are the updated values for the pixel currently presented; state registers them.
// No backpressure: advances whenever step is asserted while active.
module cell_axis_counter
  import tetris_pkg::*;
#(
  parameter int COUNT     = 10,
  parameter int CELL_LOG2 = 4,
  parameter int IDX_W     = $clog2(COUNT),
  parameter int BASE_W    = 8,
  parameter int BASE_STEP = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 step,
  input  logic                 clear,
  output logic [IDX_W-1:0]     idx,
  output logic [CELL_LOG2-1:0] sub,
  output logic                 active,
  output logic                 sub_zero,
  output logic [BASE_W-1:0]    base
);

  localparam logic [CELL_LOG2-1:0] SUB_MAX  = '1;
  localparam logic [CELL_LOG2-1:0] SUB_ONE  = CELL_LOG2'(1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(COUNT - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [BASE_W-1:0]    BASE_INC = BASE_W'(BASE_STEP);

  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [CELL_LOG2-1:0] sub_q, sub_n;
  logic                 act_q, act_n;
  logic [BASE_W-1:0]    base_q, base_n;

  // Next-state: restart wins, otherwise step through sub-pixels and cells; clear drops active last
  always_comb begin
    idx_n  = idx_q;
    sub_n  = sub_q;
    act_n  = act_q;
    base_n = base_q;
    if (restart) begin
      idx_n  = '0;
      sub_n  = '0;
      base_n = '0;
      act_n  = 1'b1;
    end else begin
      if (step && act_q) begin
        if (sub_q == SUB_MAX) begin
          sub_n = '0;
          // Leaving the last cell ends the active span; idx/base hold at the last cell
          if (idx_q == IDX_LAST) begin
            act_n = 1'b0;
          end else begin
            idx_n  = idx_q + IDX_ONE;
            base_n = base_q + BASE_INC;
          end
        end else begin
          sub_n = sub_q + SUB_ONE;
        end
      end
      if (clear) begin
        act_n = 1'b0;
      end
    end
  end

  // Axis state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      sub_q  <= '0;
      act_q  <= 1'b0;
      base_q <= '0;
    end else begin
      idx_q  <= idx_n;
      sub_q  <= sub_n;
      act_q  <= act_n;
      base_q <= base_n;
    end
  end

  // Outputs describe the pixel being presented this cycle
  assign idx      = idx_n;
  assign sub      = sub_n;
  assign active   = act_n;
  assign sub_zero = (sub_n == '0);
  assign base     = base_n;

endmodule

// File: rtl/board_cell_fetch.sv
// Scan-side board reader: beam position -> board RAM address -> 3-bit cell type per pixel.
// Fixed 2-clk latency from (hpos,vpos,de) to (cell_type,in_board,de_out); rd_addr is same-cycle.
// No backpressure: the pipeline never stalls. Optional macro GRID_EN blanks cell edges to draw a 1-px grid.
module board_cell_fetch
  import tetris_pkg::*;
#(
  parameter int         COLS      = BOARD_COLS,
  parameter int         ROWS      = BOARD_ROWS,
  parameter int         CELL_LOG2 = 4,
  parameter logic [9:0] ORIGIN_X  = 10'd240,
  parameter logic [9:0] ORIGIN_Y  = 10'd80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              de,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CELL_W-1:0] rd_data,
  output logic [CELL_W-1:0] cell_type,
  output logic              in_board,
  output logic              de_out
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  // Stage 0: axis control decoded from the beam position
  logic line_start;
  logic x_restart;
  logic y_restart;

  assign line_start = (hpos == 10'd0);
  assign x_restart  = (hpos == ORIGIN_X);
  assign y_restart  = line_start && (vpos == ORIGIN_Y);

  logic [COL_W-1:0]     col_idx;
  logic [CELL_LOG2-1:0] subx;
  logic                 col_active;
  logic                 subx_zero;
  logic [ADDR_W-1:0]    col_base;

  logic [ROW_W-1:0]     row_idx;
  logic [CELL_LOG2-1:0] suby;
  logic                 row_active;
  logic                 suby_zero;
  logic [ADDR_W-1:0]    row_base;

  // Horizontal axis: starts at the board left edge, a new line always drops it
  cell_axis_counter #(
    .COUNT     (COLS),
    .CELL_LOG2 (CELL_LOG2),
    .IDX_W     (COL_W),
    .BASE_W    (ADDR_W),
    .BASE_STEP (0)
  ) u_xaxis (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (x_restart),
    .step     (1'b1),
    .clear    (line_start),
    .idx      (col_idx),
    .sub      (subx),
    .active   (col_active),
    .sub_zero (subx_zero),
    .base     (col_base)
  );

  // Vertical axis: only moves at line start; row_base tracks row*COLS without a multiplier
  cell_axis_counter #(
    .COUNT     (ROWS),
    .CELL_LOG2 (CELL_LOG2),
    .IDX_W     (ROW_W),
    .BASE_W    (ADDR_W),
    .BASE_STEP (COLS)
  ) u_yaxis (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (y_restart),
    .step     (line_start),
    .clear    (1'b0),
    .idx      (row_idx),
    .sub      (suby),
    .active   (row_active),
    .sub_zero (suby_zero),
    .base     (row_base)
  );

  // RAM address for the current pixel; held at 0 while in reset
  always_comb begin
    rd_addr = '0;
    if (rst_n) begin
      rd_addr = row_base + ADDR_W'(col_idx);
    end
  end

  // Stage-0 pixel flags travelling alongside the RAM read
  logic in0;
  logic grid0;

  assign in0   = de && row_active && col_active;
  assign grid0 = subx_zero || suby_zero;

  logic in_p;
  logic de_p;
  logic grid_p;

  // Stage 1: align pixel flags with the RAM read in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_p   <= 1'b0;
      de_p   <= 1'b0;
      grid_p <= 1'b0;
    end else begin
      in_p   <= in0;
      de_p   <= de;
      grid_p <= grid0;
    end
  end

  // Stage 2: register the cell type, zero outside the board (and on grid lines when enabled)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cell_type <= T_NONE;
      in_board  <= 1'b0;
      de_out    <= 1'b0;
    end else begin
      in_board <= in_p;
      de_out   <= de_p;
`ifdef GRID_EN
      cell_type <= (in_p && !grid_p) ? rd_data : T_NONE;
`else
      cell_type <= in_p ? rd_data : T_NONE;
`endif
    end
  end

  // Counter outputs not needed by this reader
  logic unused_bits;
`ifdef GRID_EN
  assign unused_bits = ^{row_idx, subx, suby, col_base};
`else
  assign unused_bits = ^{row_idx, subx, suby, col_base, grid_p};
`endif

endmodule

// File: tb/tb_board_cell_fetch.sv
// Directed bench for board_cell_fetch with a 1-clk sync RAM model holding a%8 at address a.
// Lines are driven pixel by pixel; lines of no interest are a single hpos=0 cycle.
// Outputs for pixel h appear in the snapshot taken two pixels later.
module tb_board_cell_fetch;
  import tetris_pkg::*;

  localparam int LINE_END = 409;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hpos  = '0;
  logic [9:0] vpos  = '0;
  logic       de    = 1'b0;
  logic [7:0] rd_addr;
  logic [2:0] rd_data;
  logic [2:0] cell_type;
  logic       in_board;
  logic       de_out;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] cur_addr;
  logic [2:0] cur_ct;
  logic       cur_ib;
  logic       cur_deo;

  logic [7:0] addr_at [0:511];
  logic [2:0] ct_at   [0:511];
  logic       ib_at   [0:511];
  logic       deo_at  [0:511];

  always #5 clk = ~clk;

  // Sync RAM model: address a holds a%8, one clock of latency
  always @(posedge clk) rd_data <= rd_addr[2:0];

  board_cell_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hpos      (hpos),
    .vpos      (vpos),
    .de        (de),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cell_type (cell_type),
    .in_board  (in_board),
    .de_out    (de_out)
  );

  // Expected {in_board, cell_type} for one pixel of a fully synchronised frame
  function automatic logic [3:0] gold(input int h, input int v, input logic d);
    int addr;
    logic [3:0] r;
    r = 4'b0000;
    if (d && h >= 240 && h < 400 && v >= 80 && v < 400) begin
      addr = ((v - 80) / 16) * 10 + (h - 240) / 16;
      r = {1'b1, 3'(addr % 8)};
`ifdef GRID_EN
      if (((h - 240) % 16) == 0 || ((v - 80) % 16) == 0) r[2:0] = 3'b000;
`endif
    end
    return r;
  endfunction

  task automatic px(input int h, input int v, input logic d);
    hpos = h[9:0];
    vpos = v[9:0];
    de   = d;
    @(negedge clk);
    cur_addr = rd_addr;
    cur_ct   = cell_type;
    cur_ib   = in_board;
    cur_deo  = de_out;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input int h);
    addr_at[h] = cur_addr;
    ct_at[h]   = cur_ct;
    ib_at[h]   = cur_ib;
    deo_at[h]  = cur_deo;
  endtask

  task automatic run_line(input int v, input logic d);
    for (int h = 0; h <= LINE_END; h++) begin
      px(h, v, d);
      store(h);
    end
  endtask

  task automatic skip_lines(input int v0, input int v1);
    for (int v = v0; v <= v1; v++) px(0, v, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) px(240, 80, 1'b1);
    vectors++; if (cur_ct !== 3'b000) begin miscompares++; $display("FAIL reset_cell_type got %0h want 0", cur_ct); end
    vectors++; if (cur_ib !== 1'b0) begin miscompares++; $display("FAIL reset_in_board got %0b want 0", cur_ib); end
    vectors++; if (cur_deo !== 1'b0) begin miscompares++; $display("FAIL reset_de_out got %0b want 0", cur_deo); end
    vectors++; if (cur_addr !== 8'd0) begin miscompares++; $display("FAIL reset_rd_addr got %0d want 0", cur_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midline;
    skip_lines(0, 99);
    for (int h = 0; h <= LINE_END; h++) begin
      rst_n = (h >= 300 && h <= 302) ? 1'b0 : 1'b1;
      px(h, 100, 1'b1);
      store(h);
    end
    rst_n = 1'b1;
    // pixel (297,100): row 1 col 3 -> addr 13 -> type 5
    vectors++; if (ib_at[299] !== 1'b1) begin miscompares++; $display("FAIL prereset_in_board got %0b want 1", ib_at[299]); end
    vectors++; if (ct_at[299] !== 3'd5) begin miscompares++; $display("FAIL prereset_type got %0d want 5", ct_at[299]); end
    vectors++; if (addr_at[300] !== 8'd0) begin miscompares++; $display("FAIL reset_addr_h300 got %0d want 0", addr_at[300]); end
    for (int h = 301; h <= 304; h++) begin
      vectors++;
      if (ib_at[h] !== 1'b0 || ct_at[h] !== 3'b000 || deo_at[h] !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_zero h=%0d got ib=%0b ct=%0d de=%0b want 0/0/0", h, ib_at[h], ct_at[h], deo_at[h]);
      end
    end
    for (int h = 305; h <= LINE_END; h++) begin
      vectors++;
      if (ib_at[h] !== 1'b0 || ct_at[h] !== 3'b000 || deo_at[h] !== 1'b1) begin
        miscompares++;
        $display("FAIL postreset_line h=%0d got ib=%0b ct=%0d de=%0b want 0/0/1", h, ib_at[h], ct_at[h], deo_at[h]);
      end
    end
    // rows stay inactive until the next frame start
    run_line(101, 1'b1);
    vectors++; if (ib_at[302] !== 1'b0) begin miscompares++; $display("FAIL postreset_row_inactive got %0b want 0", ib_at[302]); end
    skip_lines(102, 401);
  endtask

  task automatic test_outside_edges;
    skip_lines(0, 78);
    run_line(79, 1'b1);
    vectors++; if (ib_at[242] !== 1'b0) begin miscompares++; $display("FAIL above_board_ib got %0b want 0", ib_at[242]); end
    vectors++; if (ct_at[242] !== 3'b000) begin miscompares++; $display("FAIL above_board_type got %0d want 0", ct_at[242]); end
  endtask

  task automatic test_origin_line;
    logic [3:0] g;
    run_line(80, 1'b1);
    vectors++; if (ib_at[241] !== 1'b0) begin miscompares++; $display("FAIL left_of_board_ib got %0b want 0", ib_at[241]); end
    vectors++; if (ct_at[241] !== 3'b000) begin miscompares++; $display("FAIL left_of_board_type got %0d want 0", ct_at[241]); end
    vectors++; if (addr_at[240] !== 8'd0) begin miscompares++; $display("FAIL origin_addr got %0d want 0", addr_at[240]); end
    vectors++; if (ib_at[242] !== 1'b1) begin miscompares++; $display("FAIL origin_ib got %0b want 1", ib_at[242]); end
    vectors++; if (ct_at[242] !== 3'd0) begin miscompares++; $display("FAIL origin_type got %0d want 0", ct_at[242]); end
    vectors++; if (addr_at[256] !== 8'd1) begin miscompares++; $display("FAIL second_cell_addr got %0d want 1", addr_at[256]); end
`ifdef GRID_EN
    vectors++; if (ct_at[258] !== 3'd0) begin miscompares++; $display("FAIL second_cell_type got %0d want 0", ct_at[258]); end
`else
    vectors++; if (ct_at[258] !== 3'd1) begin miscompares++; $display("FAIL second_cell_type got %0d want 1", ct_at[258]); end
`endif
    // whole line against the golden model, first full frame after reset
    for (int h = 2; h <= LINE_END; h++) begin
      g = gold(h - 2, 80, 1'b1);
      vectors++;
      if ({ib_at[h], ct_at[h]} !== g || deo_at[h] !== 1'b1) begin
        miscompares++;
        $display("FAIL line80 pixel=%0d got ib=%0b ct=%0d de=%0b want ib=%0b ct=%0d de=1", h - 2, ib_at[h], ct_at[h], deo_at[h], g[3], g[2:0]);
      end
    end
  endtask

  task automatic test_grid;
    skip_lines(81, 95);
    run_line(96, 1'b1);
    vectors++; if (addr_at[256] !== 8'd11) begin miscompares++; $display("FAIL row1_addr got %0d want 11", addr_at[256]); end
    vectors++; if (ib_at[258] !== 1'b1) begin miscompares++; $display("FAIL grid_corner_ib got %0b want 1", ib_at[258]); end
`ifdef GRID_EN
    vectors++; if (ct_at[258] !== 3'd0) begin miscompares++; $display("FAIL grid_corner_type got %0d want 0", ct_at[258]); end
`else
    vectors++; if (ct_at[258] !== 3'd3) begin miscompares++; $display("FAIL grid_corner_type got %0d want 3", ct_at[258]); end
`endif
    run_line(97, 1'b1);
    vectors++; if (addr_at[257] !== 8'd11) begin miscompares++; $display("FAIL inner_addr got %0d want 11", addr_at[257]); end
    vectors++; if (ib_at[259] !== 1'b1) begin miscompares++; $display("FAIL inner_ib got %0b want 1", ib_at[259]); end
    vectors++; if (ct_at[259] !== 3'd3) begin miscompares++; $display("FAIL inner_type got %0d want 3", ct_at[259]); end
  endtask

  task automatic test_de_low;
    skip_lines(98, 119);
    run_line(120, 1'b0);
    for (int h = 2; h <= LINE_END; h++) begin
      vectors++;
      if (deo_at[h] !== 1'b0 || ib_at[h] !== 1'b0) begin
        miscompares++;
        $display("FAIL de_low_line h=%0d got de=%0b ib=%0b want 0/0", h, deo_at[h], ib_at[h]);
      end
    end
    run_line(121, 1'b1);
    vectors++; if (addr_at[240] !== 8'd20) begin miscompares++; $display("FAIL row2_base got %0d want 20", addr_at[240]); end
    vectors++; if (addr_at[256] !== 8'd21) begin miscompares++; $display("FAIL row2_col1 got %0d want 21", addr_at[256]); end
    vectors++; if (ib_at[243] !== 1'b1) begin miscompares++; $display("FAIL row2_ib got %0b want 1", ib_at[243]); end
    vectors++; if (ct_at[243] !== 3'd4) begin miscompares++; $display("FAIL row2_type got %0d want 4", ct_at[243]); end
  endtask

  task automatic test_corner;
    logic [3:0] g;
    skip_lines(122, 398);
    run_line(399, 1'b1);
    vectors++; if (addr_at[399] !== 8'd199) begin miscompares++; $display("FAIL last_cell_addr got %0d want 199", addr_at[399]); end
    vectors++; if (ib_at[401] !== 1'b1) begin miscompares++; $display("FAIL last_cell_ib got %0b want 1", ib_at[401]); end
    vectors++; if (ct_at[401] !== 3'd7) begin miscompares++; $display("FAIL last_cell_type got %0d want 7", ct_at[401]); end
    vectors++; if (ib_at[402] !== 1'b0) begin miscompares++; $display("FAIL right_edge_ib got %0b want 0", ib_at[402]); end
    vectors++; if (ct_at[402] !== 3'd0) begin miscompares++; $display("FAIL right_edge_type got %0d want 0", ct_at[402]); end
    for (int h = 2; h <= LINE_END; h++) begin
      g = gold(h - 2, 399, 1'b1);
      vectors++;
      if ({ib_at[h], ct_at[h]} !== g) begin
        miscompares++;
        $display("FAIL line399 pixel=%0d got ib=%0b ct=%0d want ib=%0b ct=%0d", h - 2, ib_at[h], ct_at[h], g[3], g[2:0]);
      end
    end
    run_line(400, 1'b1);
    for (int h = 2; h <= LINE_END; h++) begin
      vectors++;
      if (ib_at[h] !== 1'b0 || ct_at[h] !== 3'd0 || deo_at[h] !== 1'b1) begin
        miscompares++;
        $display("FAIL below_board h=%0d got ib=%0b ct=%0d de=%0b want 0/0/1", h, ib_at[h], ct_at[h], deo_at[h]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_midline();
    test_outside_edges();
    test_origin_line();
    test_grid();
    test_de_low();
    test_corner();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
